// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and AXI constants for the icache/dcache read arbiter.
// Requester indices double as bit positions in the two-bit request vector.
package axi_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    function automatic logic [7:0] calc_arlen(input logic cached, input int line_beats);
        return cached ? 8'(line_beats - 1) : 8'd0;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arb2.sv
// Two-input round-robin picker. On a tie the requester that did not win
// last time is chosen; the last-grant register only moves when update is set.
module rr_arb2
    import axi_read_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_valid,
    output logic       grant
);

    logic last_q, last_d;

    always_comb begin
        grant_valid = |req;
        grant       = REQ_INST;
        if (req[REQ_INST] && req[REQ_DATA]) begin
            grant = ~last_q;
        end else if (req[REQ_DATA]) begin
            grant = REQ_DATA;
        end
        last_d = last_q;
        if (update && grant_valid) begin
            last_d = grant;
        end
    end

    // Reset to INST so the data cache wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_INST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Single-outstanding AXI read arbiter between icache and dcache: registered
// grant, AR issue, and R-beat routing to the granted requester until rlast.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int         LINE_BEATS = 16,
    parameter logic [3:0] INST_ID    = 4'd0,
    parameter logic [3:0] DATA_ID    = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_rreq,
    input  logic [31:0] inst_raddr,
    input  logic        inst_cached,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    output logic        inst_rlast,
    input  logic        data_rreq,
    input  logic [31:0] data_raddr,
    input  logic        data_cached,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    output logic        data_rlast,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        busy,
    output logic        err
);

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [31:0] addr_q, addr_d;
    logic        cached_q, cached_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  cnt_q, cnt_d;

    logic arb_valid, arb_grant, arb_update;
    logic in_data, beat, inst_sel, data_sel;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         ({data_rreq, inst_rreq}),
        .update      (arb_update),
        .grant_valid (arb_valid),
        .grant       (arb_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= REQ_INST;
            addr_q   <= 32'd0;
            cached_q <= 1'b0;
            id_q     <= 4'd0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            cached_q <= cached_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_valid)        state_d = ST_ADDR;
            ST_ADDR: if (arready)          state_d = ST_DATA;
            ST_DATA: if (rvalid && rlast)  state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // AR registers are loaded only when leaving IDLE, so they stay frozen while arvalid is up.
    always_comb begin
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        cached_d   = cached_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        arb_update = 1'b0;
        if (state_q == ST_IDLE && arb_valid) begin
            arb_update = 1'b1;
            gnt_d      = arb_grant;
            addr_d     = (arb_grant == REQ_DATA) ? data_raddr  : inst_raddr;
            cached_d   = (arb_grant == REQ_DATA) ? data_cached : inst_cached;
            id_d       = (arb_grant == REQ_DATA) ? DATA_ID     : INST_ID;
        end
        if (state_q == ST_ADDR && arready) begin
            cnt_d = 8'd0;
        end
        if (state_q == ST_DATA && rvalid) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        in_data  = (state_q == ST_DATA);
        beat     = in_data && rvalid;
        inst_sel = in_data && (gnt_q == REQ_INST);
        data_sel = in_data && (gnt_q == REQ_DATA);

        arvalid  = (state_q == ST_ADDR);
        rready   = in_data;
        busy     = (state_q != ST_IDLE);

        arid     = id_q;
        araddr   = addr_q;
        arlen    = calc_arlen(cached_q, LINE_BEATS);
        arburst  = cached_q ? BURST_INCR : BURST_FIXED;
        arsize   = SIZE_4B;
        arlock   = 2'b00;
        arcache  = 4'b0000;
        arprot   = 3'b000;

        inst_addr_ok = arvalid && arready && (gnt_q == REQ_INST);
        data_addr_ok = arvalid && arready && (gnt_q == REQ_DATA);

        inst_rvalid = inst_sel && rvalid;
        inst_rlast  = inst_sel && rlast;
        inst_rdata  = inst_sel ? rdata : 32'd0;
        data_rvalid = data_sel && rvalid;
        data_rlast  = data_sel && rlast;
        data_rdata  = data_sel ? rdata : 32'd0;

        err = beat && ((rresp != RESP_OKAY) || (rid != id_q) ||
                       (rlast && (cnt_q != arlen)) || ((cnt_q == arlen) && !rlast));
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomised bench for axi_read_arbiter: a round-robin grant model plus an
// AXI slave that injects response, id and beat-count errors on chosen beats.
module tb_axi_read_arbiter;

    localparam int         LINE_BEATS = 16;
    localparam logic [3:0] INST_ID    = 4'd0;
    localparam logic [3:0] DATA_ID    = 4'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_rreq = 0, inst_cached = 0, data_rreq = 0, data_cached = 0;
    logic [31:0] inst_raddr = 0, data_raddr = 0;
    logic        inst_addr_ok, inst_rvalid, inst_rlast, data_addr_ok, data_rvalid, data_rlast;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid, arcache;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, rready, busy, err;
    logic        arready = 0, rlast = 0, rvalid = 0;
    logic [3:0]  rid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0;

    always #5 clk = ~clk;

    axi_read_arbiter #(.LINE_BEATS(LINE_BEATS), .INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
        .clk(clk), .rst(rst),
        .inst_rreq(inst_rreq), .inst_raddr(inst_raddr), .inst_cached(inst_cached),
        .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
        .inst_rlast(inst_rlast),
        .data_rreq(data_rreq), .data_raddr(data_raddr), .data_cached(data_cached),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_rvalid(data_rvalid),
        .data_rlast(data_rlast),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .busy(busy), .err(err)
    );

    int checks = 0;
    int failures = 0;
    int txn_no = 0;

    // Reference state: who won last (0 = inst, 1 = data) and outstanding requests.
    bit last_data = 1'b0;
    bit inst_pend = 1'b0;
    bit data_pend = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (txn %0d)", tag, got, exp, txn_no);
        end
    endtask

    // Called just after a falling edge with the arbiter idle.
    // err_mode: 0 clean, 1 bad rresp, 2 early rlast, 3 bad rid, 4 late rlast.
    // eb < 0 picks a random error beat; rst_beat > 0 resets on that (1-based) beat.
    task automatic run_txn(input bit want_i, input bit want_d,
                           input logic [31:0] ai, input logic [31:0] ad,
                           input bit ci, input bit cd,
                           input int err_mode, input int eb_in,
                           input int stall, input int rst_beat);
        bit          win_d;
        logic [31:0] exp_addr;
        logic [3:0]  exp_id;
        bit          exp_cached;
        int          nb, eb, total, last_at, exp_len;
        logic [31:0] got_data, got_other_data;
        logic        got_v, got_l, got_ov, exp_err;

        if (want_i && !inst_pend) begin
            inst_rreq = 1; inst_raddr = ai; inst_cached = ci; inst_pend = 1;
        end
        if (want_d && !data_pend) begin
            data_rreq = 1; data_raddr = ad; data_cached = cd; data_pend = 1;
        end
        #1;
        check("idle_arvalid", arvalid, 0);
        check("idle_busy", busy, 0);
        check("idle_rready", rready, 0);

        win_d      = (inst_pend && data_pend) ? !last_data : data_pend;
        last_data  = win_d;
        exp_addr   = win_d ? data_raddr : inst_raddr;
        exp_cached = win_d ? data_cached : inst_cached;
        exp_id     = win_d ? DATA_ID : INST_ID;
        nb         = exp_cached ? LINE_BEATS : 1;
        exp_len    = nb - 1;
        $display("txn %0d: grant=%s addr=%08h cached=%0d stall=%0d mode=%0d",
                 txn_no, win_d ? "DATA" : "INST", exp_addr, exp_cached, stall, err_mode);

        // Address phase; junk R beats are offered and must be refused.
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            arready = (s == stall);
            rvalid  = (s != stall);
            rlast   = (s != stall);
            #1;
            check("ar_valid", arvalid, 1);
            check("ar_addr", araddr, exp_addr);
            check("ar_id", arid, exp_id);
            check("ar_len", arlen, 64'(exp_len));
            check("ar_burst", arburst, exp_cached ? 2'b01 : 2'b00);
            check("ar_size", arsize, 3'b010);
            check("ar_misc", {arlock, arcache, arprot}, 0);
            check("inst_addr_ok", inst_addr_ok, (s == stall) && !win_d);
            check("data_addr_ok", data_addr_ok, (s == stall) && win_d);
            check("addr_rready", rready, 0);
            check("addr_rvalid", {inst_rvalid, data_rvalid}, 0);
        end

        @(negedge clk);
        arready = 0; rvalid = 0; rlast = 0;
        if (win_d) begin data_rreq = 0; data_pend = 0; end
        else       begin inst_rreq = 0; inst_pend = 0; end

        eb = (eb_in >= 0) ? eb_in : $urandom_range(0, nb - 1);
        total = nb;
        if (err_mode == 2) total = eb + 1;
        if (err_mode == 4) total = nb + 1;
        last_at = total - 1;

        for (int b = 0; b < total; b++) begin
            repeat ($urandom_range(0, 2)) begin
                rvalid = 0; rlast = 0;
                #1;
                check("gap_rready", rready, 1);
                check("gap_rvalid", {inst_rvalid, data_rvalid}, 0);
                check("gap_err", err, 0);
                @(negedge clk);
            end
            rvalid = 1;
            rdata  = $urandom;
            rlast  = (b == last_at);
            rid    = (err_mode == 3 && b == eb) ? (exp_id ^ 4'h8) : exp_id;
            rresp  = (err_mode == 1 && b == eb) ? 2'b10 : 2'b00;
            if (rst_beat > 0 && b == rst_beat - 1) begin
                #1;
                rst = 1;
                #1;
                check("rst_arvalid", arvalid, 0);
                check("rst_rready", rready, 0);
                check("rst_busy", busy, 0);
                check("rst_rvalid", {inst_rvalid, data_rvalid}, 0);
                rvalid = 0; rlast = 0; rid = 0; rresp = 0;
                inst_rreq = 0; data_rreq = 0;
                inst_pend = 0; data_pend = 0;
                last_data = 0;
                @(negedge clk);
                @(negedge clk);
                rst = 0;
                txn_no++;
                return;
            end
            exp_err = (rresp != 2'b00) || (rid != exp_id) ||
                      (rlast && b != exp_len) || (b == exp_len && !rlast);
            #1;
            got_v          = win_d ? data_rvalid : inst_rvalid;
            got_l          = win_d ? data_rlast  : inst_rlast;
            got_data       = win_d ? data_rdata  : inst_rdata;
            got_ov         = win_d ? inst_rvalid : data_rvalid;
            got_other_data = win_d ? inst_rdata  : data_rdata;
            check("beat_rvalid", got_v, 1);
            check("beat_rlast", got_l, rlast);
            check("beat_rdata", got_data, rdata);
            check("other_rvalid", got_ov, 0);
            check("other_rdata", got_other_data, 0);
            check("beat_err", err, exp_err);
            @(negedge clk);
        end
        rvalid = 0; rlast = 0; rid = 0; rresp = 0;
        txn_no++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_arvalid", arvalid, 0);
        check("reset_rready", rready, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        check("reset_rvalid", {inst_rvalid, data_rvalid, inst_rlast, data_rlast}, 0);
        check("reset_rdata", {inst_rdata, data_rdata}, 0);
        @(negedge clk);
        rst = 0;

        // Cached inst refill, then a tie where data wins and inst follows.
        run_txn(1, 0, 32'hBFC0_0000, 32'h0, 1, 0, 0, -1, 0, 0);
        run_txn(1, 1, 32'hBFC0_0040, 32'h8000_1000, 1, 0, 0, -1, 0, 0);
        run_txn(0, 0, 32'h0, 32'h0, 0, 0, 0, -1, 0, 0);

        // Continuous contention: D,I,D,I with one long arready stall.
        run_txn(1, 1, $urandom, $urandom, 0, 1, 0, -1, 5, 0);
        run_txn(1, 1, $urandom, $urandom, 1, 0, 0, -1, 0, 0);
        run_txn(1, 1, $urandom, $urandom, 0, 0, 0, -1, 2, 0);
        run_txn(0, 0, 32'h0, 32'h0, 0, 0, 0, -1, 0, 0);

        // Bad rresp on beat 3, then early rlast on beat 10 of a line.
        run_txn(1, 0, 32'h0000_1000, 32'h0, 1, 0, 1, 2, 0, 0);
        run_txn(0, 1, 32'h0, 32'h0000_2000, 0, 1, 2, 9, 0, 0);
        run_txn(1, 0, 32'h0000_3000, 32'h0, 1, 0, 4, -1, 1, 0);

        for (int i = 0; i < 20; i++) begin
            bit wi, wd;
            wi = $urandom_range(0, 1);
            wd = $urandom_range(0, 1);
            if (!wi && !wd && !inst_pend && !data_pend) wd = 1;
            run_txn(wi, wd, $urandom, $urandom, 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 4)), -1, int'($urandom_range(0, 3)), 0);
        end
        while (inst_pend || data_pend) begin
            run_txn(0, 0, 32'h0, 32'h0, 0, 0, 0, -1, 0, 0);
        end

        // Reset on beat 7 of a cached line; afterwards data wins the tie again.
        run_txn(1, 0, 32'h1FC0_0000, 32'h0, 1, 0, 0, -1, 0, 7);
        run_txn(1, 1, 32'h1FC0_0100, 32'h8000_4000, 0, 0, 0, -1, 0, 0);
        run_txn(0, 0, 32'h0, 32'h0, 0, 0, 0, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
Sequenced AXI read-channel arbiter between the instruction cache and the data cache, replacing steering driven by requester enables with a registered grant. It owns a single outstanding AXI read transaction at a time. It arbitrates round-robin between the two requesters, drives AR, and routes R beats back to the granted requester until rlast. It sits between the L1 caches and the CPU top-level AXI read ports.

Parameters:
LINE_BEATS, 16, beats per cached line refill; arlen = LINE_BEATS-1 when cached.
INST_ID, 4'd0, arid used for instruction requests.
DATA_ID, 4'd1, arid used for data requests.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
inst_rreq  in  1  icache read request; held until inst_addr_ok
inst_raddr  in  32  icache read address
inst_cached  in  1  1 = line burst, 0 = single beat
inst_addr_ok  out  1  one-cycle pulse: AR for inst accepted
inst_rdata  out  32  read data to icache
inst_rvalid  out  1  beat valid to icache
inst_rlast  out  1  last beat to icache
data_rreq, data_raddr, data_cached, data_addr_ok, data_rdata, data_rvalid, data_rlast: same as inst_*, for dcache
arid  out  4  ; araddr out 32 ; arlen out 8 ; arsize out 3 ; arburst out 2 ; arlock out 2 ; arcache out 4 ; arprot out 3
arvalid  out  1 ; arready  in  1
rid  in  4 ; rdata  in  32 ; rresp  in  2 ; rlast  in  1 ; rvalid  in  1 ; rready  out  1
busy  out  1  FSM not in IDLE
err  out  1  one-cycle pulse on protocol/response error

Behaviour:
- States: IDLE, ADDR, DATA. Reset (async, immediate): IDLE, arvalid=0, rready=0, all *_addr_ok/*_rvalid/*_rlast=0, rdata outputs 0, last_grant=INST (data wins first tie), beat counter 0, err=0, busy=0.
- IDLE: if any rreq, choose winner. Both requesting -> grant opposite of last_grant; one requesting -> grant it. Latch addr, cached, id into AR registers; update last_grant; go ADDR. No request -> stay.
- ADDR: arvalid=1 with registered fields; arlen = cached ? LINE_BEATS-1 : 0; arburst = cached ? 2'b01 : 2'b00; arsize=3'b010; arlock/arcache/arprot=0. AR fields stable while arvalid=1. On arvalid&&arready: pulse granted *_addr_ok for that same cycle (combinational from arready), clear beat counter, go DATA.
- Latency: rreq sampled in IDLE at cycle N -> arvalid=1 at N+1; earliest addr_ok at N+1.
- DATA: rready=1. Granted requester's rvalid/rlast/rdata = AXI rvalid/rlast/rdata combinationally; non-granted requester sees 0. Each rvalid beat increments the 8-bit counter. On rvalid&&rlast -> IDLE next cycle; new AR no earlier than two cycles after rlast.
- rready=0 outside DATA. R beats arriving in IDLE/ADDR are not accepted.
- err pulses in the cycle of a DATA beat where: rresp!=0; rid != latched id; rlast with counter != arlen; or counter == arlen without rlast. The beat is still forwarded. The FSM still leaves only on rlast.
- A requester dropping rreq in ADDR is illegal. The arbiter completes the latched transaction regardless.
- No starvation: with both requesting continuously, grants alternate D,I,D,I.
- Reset mid-burst: immediate return to IDLE. Outstanding AXI beats are abandoned, which is acceptable only under whole-system reset.

Decomposition:
- Shared package/header: state encodings (IDLE/ADDR/DATA), AXI constants (SIZE_4B=3'b010, BURST_FIXED=2'b00, BURST_INCR=2'b01, RESP_OKAY=2'b00), requester index (REQ_INST=0, REQ_DATA=1).
- One natural sub-module: rr_arb2, a 2-input round-robin picker with a last-grant register and an update enable. FSM, AR registers and R routing stay in the top.

Test Plan:
- Single cached inst read: inst_rreq=1, addr 0xBFC00000, cached=1 -> arvalid next cycle, arid=0, arlen=0x0F, arburst=01. 16 beats reach inst_rdata with inst_rlast on beat 16. data_rvalid stays 0. err=0.
- Simultaneous requests after reset: both rreq=1, data addr 0x80001000 uncached -> data granted first, arlen=0, arburst=00. After rlast, inst granted with araddr=inst_raddr.
- Continuous contention over 4 transactions -> grant order D,I,D,I. Each *_addr_ok pulses exactly once per grant.
- arready held low 5 cycles -> arvalid and all AR fields stable for 5 cycles. addr_ok pulses only in the arready cycle.
- Error injection: rresp=2'b10 on beat 3; separately rlast on beat 10 of a 16-beat burst -> err pulses exactly in those beat cycles. FSM returns to IDLE after rlast.
- Async reset asserted mid-DATA (beat 7) -> arvalid, rready, busy and all *_rvalid drop immediately. After release, FSM is in IDLE and data wins the next tie.
